// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the request encoder family.
// Provides the selection-mode constants and the index wrap helper.
// No ports; imported by prio_encoder_rr and prio_encoder_rr_pick.
package prio_encoder_rr_pkg;

   localparam logic ENC_MODE_FIXED = 1'b0;
   localparam logic ENC_MODE_RR    = 1'b1;

   // Next index with an explicit wrap at n-1, so non-power-of-2 sizes
   // never step into the unused upper codes of the index field.
   function automatic int unsigned nxt_idx(input int unsigned i, input int unsigned n);
      return (i == n - 32'd1) ? 32'd0 : i + 32'd1;
   endfunction

endpackage

// File: rtl/prio_encoder_rr_pick.sv
// Purpose: combinational winner search over an N-bit request vector.
// Latency: none (pure combinational). Backpressure: n/a, caller decides when to sample.
// Ports: req (requests), pe (round-robin start index), mode (fixed/RR) ->
//        winner (index), any (req!=0), multi (more than one req bit set).
module prio_encoder_rr_pick
   import prio_encoder_rr_pkg::*;
#(
   parameter  int N = 8,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] pe,
   input  logic         mode,
   output logic [W-1:0] winner,
   output logic         any,
   output logic         multi
);

   logic [N-1:0] mask_ge;
   logic [N-1:0] masked;
   logic [W-1:0] hi_idx;
   logic [W-1:0] lo_idx;
   logic [W-1:0] lo_ge_idx;

   always_comb begin
      mask_ge   = '0;
      hi_idx    = '0;
      lo_idx    = '0;
      lo_ge_idx = '0;
      for (int i = 0; i < N; i++) begin
         mask_ge[i] = (i >= int'(pe));
      end
      masked = req & mask_ge;
      // Ascending scan: last hit is the highest set index.
      for (int i = 0; i < N; i++) begin
         if (req[i]) hi_idx = W'(i);
      end
      // Descending scan: last hit is the lowest set index.
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i])    lo_idx    = W'(i);
         if (masked[i]) lo_ge_idx = W'(i);
      end
      any = |req;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi = |(req & (req - N'(1)));
      if (mode == ENC_MODE_RR) begin
         winner = (|masked) ? lo_ge_idx : lo_idx;
      end else begin
         winner = hi_idx;
      end
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Purpose: N-bit request encoder (fixed priority or round-robin) with a 1-deep registered result.
// Latency: 1 clock from req to out_*; all outputs come straight from flops.
// Backpressure: result held while out_valid & !out_ready; new load in the same cycle as accept.
// Ports: clk, rst (sync active-high), req[N], out_ready -> out_valid, out_idx[W],
//        out_onehot[N], out_multi.
module prio_encoder_rr
   import prio_encoder_rr_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int RR = 0,
   localparam int W  = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] out_onehot,
   output logic         out_multi
);

   logic [W-1:0] ptr;
   logic [W-1:0] pe;
   logic [W-1:0] nxt_out;
   logic [W-1:0] winner;
   logic         any;
   logic         multi;
   logic         accept;
   logic         load;
   logic         mode;

   assign accept  = out_valid & out_ready;
   assign load    = !out_valid | out_ready;
   assign nxt_out = W'(nxt_idx(32'(out_idx), N));
   assign mode    = (RR != 0) ? ENC_MODE_RR : ENC_MODE_FIXED;
   // The grant being consumed this cycle already moves the search start,
   // so back-to-back grants rotate without waiting for ptr to update.
   assign pe      = (RR != 0) ? (accept ? nxt_out : ptr) : '0;

   prio_encoder_rr_pick #(.N(N)) u_pick (
      .req    (req),
      .pe     (pe),
      .mode   (mode),
      .winner (winner),
      .any    (any),
      .multi  (multi)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         out_multi  <= 1'b0;
         ptr        <= '0;
      end else begin
         // ptr advances on every accept, even if nothing new is loaded.
         if ((RR != 0) && accept) begin
            ptr <= nxt_out;
         end
         if (load) begin
            out_valid  <= any;
            out_idx    <= any ? winner : '0;
            out_onehot <= any ? (N'(1) << winner) : '0;
            out_multi  <= multi;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: fixed N=4, round-robin N=4 and round-robin N=5 instances.
// Expected results are pushed to a queue when stimulus is driven and popped at the output sample.
// Ports of every instance are driven from tasks; outputs are sampled 1 time unit after the edge.
module tb_prio_encoder_rr;

   typedef struct packed {
      logic       vld;
      logic [2:0] idx;
      logic [4:0] oh;
      logic       multi;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [3:0] req_f;  logic rdy_f;  logic vld_f;  logic [1:0] idx_f;  logic [3:0] oh_f;  logic multi_f;
   logic [3:0] req_r;  logic rdy_r;  logic vld_r;  logic [1:0] idx_r;  logic [3:0] oh_r;  logic multi_r;
   logic [4:0] req_p;  logic rdy_p;  logic vld_p;  logic [2:0] idx_p;  logic [4:0] oh_p;  logic multi_p;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   prio_encoder_rr #(.N(4), .RR(0)) dut_f (
      .clk(clk), .rst(rst), .req(req_f), .out_ready(rdy_f),
      .out_valid(vld_f), .out_idx(idx_f), .out_onehot(oh_f), .out_multi(multi_f));

   prio_encoder_rr #(.N(4), .RR(1)) dut_r (
      .clk(clk), .rst(rst), .req(req_r), .out_ready(rdy_r),
      .out_valid(vld_r), .out_idx(idx_r), .out_onehot(oh_r), .out_multi(multi_r));

   prio_encoder_rr #(.N(5), .RR(1)) dut_p (
      .clk(clk), .rst(rst), .req(req_p), .out_ready(rdy_p),
      .out_valid(vld_p), .out_idx(idx_p), .out_onehot(oh_p), .out_multi(multi_p));

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_f = '0; req_r = '0; req_p = '0;
      rdy_f = 1'b1; rdy_r = 1'b1; rdy_p = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reset held with live requests: reset must win over the load.
   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      req_f = 4'b1111; req_r = 4'b1111; req_p = 5'b11111;
      @(posedge clk); #1;
      checks++;
      if ({vld_f, idx_f, oh_f, multi_f} !== 8'b0) begin
         errors++;
         $display("FAIL reset_fixed got %b want 00000000", {vld_f, idx_f, oh_f, multi_f});
      end
      checks++;
      if ({vld_r, idx_r, oh_r, multi_r, dut_r.ptr} !== 10'b0) begin
         errors++;
         $display("FAIL reset_rr got %b want 0000000000", {vld_r, idx_r, oh_r, multi_r, dut_r.ptr});
      end
      checks++;
      if ({vld_p, idx_p, oh_p, multi_p, dut_p.ptr} !== 13'b0) begin
         errors++;
         $display("FAIL reset_rr5 got %b want 0000000000000", {vld_p, idx_p, oh_p, multi_p, dut_p.ptr});
      end
      do_reset();
   endtask

   task automatic test_fixed_onehot();
      exp_t e;
      rdy_f = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_f = 4'(1 << i);
         e.vld = 1'b1; e.idx = 3'(i); e.oh = 5'(1 << i); e.multi = 1'b0;
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_f, idx_f, oh_f, multi_f} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
            errors++;
            $display("FAIL fixed_onehot[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     i, vld_f, idx_f, oh_f, multi_f, e.vld, e.idx, e.oh[3:0], e.multi);
         end
      end
   endtask

   // Multi-hot capture, two stalled cycles with changing req, then accept with req=0.
   task automatic test_fixed_multi_hold();
      logic [3:0] reqs [4] = '{4'b1011, 4'b0001, 4'b0001, 4'b0000};
      logic       rdys [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_t e;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_f = reqs[k];
         rdy_f = rdys[k];
         e.vld = (k < 3); e.idx = (k < 3) ? 3'd3 : 3'd0;
         e.oh = (k < 3) ? 5'b01000 : 5'b0; e.multi = (k < 3);
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_f, idx_f, oh_f, multi_f} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
            errors++;
            $display("FAIL fixed_multi_hold[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     k, vld_f, idx_f, oh_f, multi_f, e.vld, e.idx, e.oh[3:0], e.multi);
         end
      end
      checks++;
      if (dut_f.ptr !== 2'd0) begin
         errors++;
         $display("FAIL fixed_ptr got %0d want 0", dut_f.ptr);
      end
      rdy_f = 1'b1;
      req_f = '0;
   endtask

   // Full-throughput rotation, then an accept with req=0 must still advance ptr.
   task automatic test_back_to_back();
      int   seq [5] = '{0, 1, 2, 3, 0};
      exp_t e;
      rdy_r = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         req_r = (k < 5) ? 4'b1111 : 4'b0000;
         if (k < 5) begin
            e.vld = 1'b1; e.idx = 3'(seq[k]); e.oh = 5'(1 << seq[k]); e.multi = 1'b1;
         end else begin
            e = '0;
         end
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_r, idx_r, oh_r, multi_r} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
            errors++;
            $display("FAIL rr_back_to_back[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     k, vld_r, idx_r, oh_r, multi_r, e.vld, e.idx, e.oh[3:0], e.multi);
         end
      end
      checks++;
      if (dut_r.ptr !== 2'd1) begin
         errors++;
         $display("FAIL rr_ptr_empty_accept got %0d want 1", dut_r.ptr);
      end
      do_reset();
   endtask

   task automatic test_rr_stall();
      logic rdys [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      int   idxs [5] = '{0, 0, 0, 0, 1};
      int   ptrs [5] = '{0, 0, 0, 0, 1};
      exp_t e;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_r = 4'b1111;
         rdy_r = rdys[k];
         e.vld = 1'b1; e.idx = 3'(idxs[k]); e.oh = 5'(1 << idxs[k]); e.multi = 1'b1;
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_r, idx_r, oh_r, multi_r} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
            errors++;
            $display("FAIL rr_stall[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     k, vld_r, idx_r, oh_r, multi_r, e.vld, e.idx, e.oh[3:0], e.multi);
         end
         checks++;
         if (int'(dut_r.ptr) != ptrs[k]) begin
            errors++;
            $display("FAIL rr_stall_ptr[%0d] got %0d want %0d", k, dut_r.ptr, ptrs[k]);
         end
      end
      do_reset();
   endtask

   task automatic test_rr_non_pow2();
      int   idxs [4] = '{0, 4, 0, 4};
      int   ptrs [4] = '{0, 1, 0, 1};
      exp_t e;
      rdy_p = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         req_p = 5'b10001;
         e.vld = 1'b1; e.idx = 3'(idxs[k]); e.oh = 5'(1 << idxs[k]); e.multi = 1'b1;
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_p, idx_p, oh_p, multi_p} !== {e.vld, e.idx, e.oh, e.multi}) begin
            errors++;
            $display("FAIL rr5[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     k, vld_p, idx_p, oh_p, multi_p, e.vld, e.idx, e.oh, e.multi);
         end
         checks++;
         if (int'(dut_p.ptr) != ptrs[k]) begin
            errors++;
            $display("FAIL rr5_ptr[%0d] got %0d want %0d", k, dut_p.ptr, ptrs[k]);
         end
      end
      do_reset();
   endtask

   task automatic test_reset_mid_stream();
      exp_t e;
      rdy_r = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_r = 4'b1111;
         e.vld = 1'b1; e.idx = 3'(k); e.oh = 5'(1 << k); e.multi = 1'b1;
         q.push_back(e);
         @(posedge clk); #1;
         e = q.pop_front();
         checks++;
         if ({vld_r, idx_r, oh_r, multi_r} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
            errors++;
            $display("FAIL mid_pre[%0d] got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                     k, vld_r, idx_r, oh_r, multi_r, e.vld, e.idx, e.oh[3:0], e.multi);
         end
      end
      @(negedge clk);
      rdy_r = 1'b0;
      rst   = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({vld_r, idx_r, oh_r, multi_r, dut_r.ptr} !== 10'b0) begin
         errors++;
         $display("FAIL mid_reset got %b want 0000000000", {vld_r, idx_r, oh_r, multi_r, dut_r.ptr});
      end
      @(negedge clk);
      rst   = 1'b0;
      rdy_r = 1'b1;
      req_r = 4'b1111;
      e.vld = 1'b1; e.idx = 3'd0; e.oh = 5'b00001; e.multi = 1'b1;
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if ({vld_r, idx_r, oh_r, multi_r} !== {e.vld, e.idx[1:0], e.oh[3:0], e.multi}) begin
         errors++;
         $display("FAIL mid_post got v=%b i=%0d oh=%b m=%b want v=%b i=%0d oh=%b m=%b",
                  vld_r, idx_r, oh_r, multi_r, e.vld, e.idx, e.oh[3:0], e.multi);
      end
      do_reset();
   endtask

   initial begin
      rst = 1'b1;
      req_f = '0; req_r = '0; req_p = '0;
      rdy_f = 1'b1; rdy_r = 1'b1; rdy_p = 1'b1;
      test_reset();
      test_fixed_onehot();
      test_fixed_multi_hold();
      test_back_to_back();
      test_rr_stall();
      test_rr_non_pow2();
      test_reset_mid_stream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
